transmit_fifo: RTL and testbench

Transmit-side buffer and sender for the UART path, mirroring the receive FIFO. The CPU pushes bytes into a 32-entry internal store. A small state machine pops them one at a time and hands each byte to the UART transmit serializer through a start/done handshake. Status flags go back to the CPU/register block.

---
 rtl/uart_pkg.sv | 15 +
 rtl/tx_fifo_mem.sv | 27 ++
 rtl/transmit_fifo.sv | 126 ++++++++++++
 tb/tb_transmit_fifo.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART FIFO constants and transmit FSM state type.
// Used by both the transmit and the receive FIFO.
package uart_pkg;

  localparam int unsigned UART_FIFO_DEPTH = 32;
  localparam int unsigned UART_FIFO_AW    = 5;
  localparam int unsigned UART_DW         = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    WAIT = 2'd2
  } tx_state_t;

endpackage

// File: rtl/tx_fifo_mem.sv
// DEPTH x DW register file for the transmit FIFO.
// Synchronous write port; combinational read port.
module tx_fifo_mem #(
  parameter int unsigned DEPTH = 32,
  parameter int unsigned AW    = 5,
  parameter int unsigned DW    = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem_q [DEPTH];

  // Contents are deliberately not reset; only the pointers are.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/transmit_fifo.sv
// UART transmit FIFO: CPU-side byte store plus a sender FSM that hands one byte
// at a time to the serializer via a tx_start / TXdone handshake.
module transmit_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH = UART_FIFO_DEPTH,
  parameter int unsigned AW    = UART_FIFO_AW,
  parameter int unsigned DW    = UART_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          fifowr,
  input  logic [DW-1:0] wdata,
  input  logic          tx_en,
  input  logic          TXdone,
  input  logic          ovf_clr,
  output logic          fifofull,
  output logic          notempty,
  output logic [AW:0]   count,
  output logic          overflow,
  output logic [DW-1:0] tx_data,
  output logic          tx_start,
  output logic          tx_busy
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  tx_state_t     state_q, state_d;
  logic [AW-1:0] wrptr_q, wrptr_d;
  logic [AW-1:0] rdptr_q, rdptr_d;
  logic [AW:0]   count_q, count_d;
  logic          overflow_q, overflow_d;
  logic [DW-1:0] tx_data_q, tx_data_d;
  logic [DW-1:0] rdata;
  logic          pop;
  logic          write;
  logic          avail;

  assign avail = tx_en && (count_q != '0);

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (avail) begin
          state_d = SEND;
          pop     = 1'b1;
        end
      end
      SEND: state_d = WAIT;
      WAIT: begin
        if (TXdone) begin
          if (avail) begin
            state_d = SEND;
            pop     = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A pop on the same edge frees a slot, so a write at full is still accepted.
  assign write = fifowr && ((count_q != FULL_CNT) || pop);

  always_comb begin
    wrptr_d    = write ? wrptr_q + 1'b1 : wrptr_q;
    rdptr_d    = pop ? rdptr_q + 1'b1 : rdptr_q;
    tx_data_d  = pop ? rdata : tx_data_q;
    count_d    = count_q;
    unique case ({write, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    overflow_d = overflow_q;
    if (fifowr && !write) begin
      overflow_d = 1'b1;
    end else if (ovf_clr) begin
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      wrptr_q    <= '0;
      rdptr_q    <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      tx_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      wrptr_q    <= wrptr_d;
      rdptr_q    <= rdptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      tx_data_q  <= tx_data_d;
    end
  end

  tx_fifo_mem #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .DW    (DW)
  ) u_mem (
    .clk   (clk),
    .we    (write),
    .waddr (wrptr_q),
    .wdata (wdata),
    .raddr (rdptr_q),
    .rdata (rdata)
  );

  assign fifofull = (count_q == FULL_CNT);
  assign notempty = (count_q != '0);
  assign count    = count_q;
  assign overflow = overflow_q;
  assign tx_data  = tx_data_q;
  assign tx_start = (state_q == SEND);
  assign tx_busy  = (state_q != IDLE);

endmodule

// File: tb/tb_transmit_fifo.sv
// Randomised scoreboard bench for transmit_fifo with a queue-based reference model.
module tb_transmit_fifo;

  logic       clk, rst, fifowr, tx_en, TXdone, ovf_clr;
  logic [7:0] wdata;
  logic       fifofull, notempty, overflow, tx_start, tx_busy;
  logic [5:0] count;
  logic [7:0] tx_data;

  int checks = 0;
  int errors = 0;

  transmit_fifo #(.DEPTH(32), .AW(5), .DW(8)) dut (
    .clk(clk), .rst(rst), .fifowr(fifowr), .wdata(wdata), .tx_en(tx_en),
    .TXdone(TXdone), .ovf_clr(ovf_clr), .fifofull(fifofull), .notempty(notempty),
    .count(count), .overflow(overflow), .tx_data(tx_data), .tx_start(tx_start),
    .tx_busy(tx_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: store is a byte queue; a transfer is idle, starting, or awaiting done.
  logic [7:0] mq[$];
  logic [7:0] sb[$];
  bit         mbusy, mstart, movf, pop_now, accepted;
  logic [7:0] mdata;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete(); sb.delete();
      mbusy = 0; mstart = 0; movf = 0; mdata = '0;
    end else begin
      pop_now = 0;
      if (!mbusy || (!mstart && TXdone))
        pop_now = tx_en && (mq.size() != 0);
      if (mbusy && !mstart && TXdone && !pop_now)
        mbusy = 0;
      accepted = fifowr && (mq.size() < 32 || pop_now);
      if (fifowr && !accepted) movf = 1;
      else if (ovf_clr) movf = 0;
      if (pop_now) begin
        mdata = mq.pop_front();
        mbusy = 1;
      end
      mstart = pop_now;
      if (accepted) begin
        mq.push_back(wdata);
        sb.push_back(wdata);
      end
    end
  end

  // Monitor: cycle-accurate flag checks plus in-order payload check on every tx_start.
  always @(negedge clk) begin
    if (!rst) begin
      check("count", 32'(count), mq.size());
      check("fifofull", 32'(fifofull), 32'(mq.size() == 32));
      check("notempty", 32'(notempty), 32'(mq.size() != 0));
      check("overflow", 32'(overflow), 32'(movf));
      check("tx_start", 32'(tx_start), 32'(mstart));
      check("tx_busy", 32'(tx_busy), 32'(mbusy));
      check("tx_data", 32'(tx_data), 32'(mdata));
      if (tx_start) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL sb_order: tx_start with data %0h but nothing expected", tx_data);
        end else begin
          check("sb_order", 32'(tx_data), 32'(sb.pop_front()));
        end
      end
    end
  end

  // Serializer stand-in: TXdone some cycles after each tx_start; optional stray pulses while idle.
  int resp_delay = 0;
  bit spur = 0;
  int rcnt = 0;
  initial begin
    TXdone = 1'b0;
    forever begin
      @(posedge clk); #1;
      TXdone = 1'b0;
      if (rst) rcnt = 0;
      else if (tx_start) rcnt = (resp_delay != 0) ? resp_delay : int'($urandom_range(1, 12));
      else if (rcnt > 0) begin
        rcnt--;
        if (rcnt == 0) TXdone = 1'b1;
      end else if (spur && !tx_busy && $urandom_range(0, 7) == 0) TXdone = 1'b1;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic push(input logic [7:0] b);
    fifowr = 1'b1; wdata = b;
    tick();
    fifowr = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int b = budget;
    while ((mq.size() != 0 || mbusy) && b > 0) begin
      tick();
      b--;
    end
    if (b == 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout: %0d bytes left after %0d cycles", mq.size(), budget);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_fifofull"}, 32'(fifofull), 0);
    check({tag, "_notempty"}, 32'(notempty), 0);
    check({tag, "_count"}, 32'(count), 0);
    check({tag, "_overflow"}, 32'(overflow), 0);
    check({tag, "_tx_data"}, 32'(tx_data), 0);
    check({tag, "_tx_start"}, 32'(tx_start), 0);
    check({tag, "_tx_busy"}, 32'(tx_busy), 0);
  endtask

  initial begin
    rst = 1'b1; fifowr = 1'b0; wdata = '0; tx_en = 1'b0; ovf_clr = 1'b0;
    repeat (3) tick();
    check_zero("reset");
    rst = 1'b0;
    tick();

    // Single byte: tx_start one cycle after the write is accepted.
    tx_en = 1'b1;
    push(8'hA5);
    check("t1_pre_start", 32'(tx_start), 0);
    tick();
    check("t1_start", 32'(tx_start), 1);
    check("t1_data", 32'(tx_data), 32'h A5);
    check("t1_count", 32'(count), 0);
    wait_drain(100);

    // Fill to full, then overflow and clear.
    tx_en = 1'b0;
    for (int i = 0; i < 32; i++) push(8'(i));
    push(8'hFF);
    check("t2_full", 32'(fifofull), 1);
    check("t2_count", 32'(count), 32);
    check("t2_ovf", 32'(overflow), 1);
    ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
    check("t2_ovf_clr", 32'(overflow), 0);

    // Drain 32 bytes with a fixed serializer time.
    resp_delay = 10; tx_en = 1'b1;
    wait_drain(1000);
    check("t3_notempty", 32'(notempty), 0);

    // Write on the same edge as a pop at full.
    tx_en = 1'b0; resp_delay = 0;
    for (int i = 0; i < 32; i++) push(8'(8'h40 + i));
    tx_en = 1'b1; fifowr = 1'b1; wdata = 8'h80;
    tick();
    fifowr = 1'b0;
    check("t4_count", 32'(count), 32);
    check("t4_start", 32'(tx_start), 1);
    for (int i = 0; i < 40; i++) begin
      fifowr = 1'($urandom_range(0, 1)); wdata = 8'($urandom);
      tick();
    end
    fifowr = 1'b0;
    wait_drain(2000);

    // Asynchronous reset while waiting for TXdone with 5 queued.
    resp_delay = 20; tx_en = 1'b1;
    for (int i = 0; i < 6; i++) push(8'(8'h10 + i));
    tick();
    check("t5_count", 32'(count), 5);
    check("t5_busy", 32'(tx_busy), 1);
    #2 rst = 1'b1;
    #1 check_zero("t5_rst");
    tick();
    rst = 1'b0;
    resp_delay = 3;
    push(8'h3C);
    wait_drain(100);

    // Drop tx_en during WAIT with 3 queued.
    resp_delay = 5;
    for (int i = 0; i < 4; i++) push(8'(8'hC0 + i));
    tx_en = 1'b0;
    repeat (20) tick();
    check("t6_count", 32'(count), 3);
    check("t6_idle", 32'(tx_busy), 0);
    tx_en = 1'b1;
    wait_drain(200);

    // Random traffic.
    resp_delay = 0; spur = 1;
    for (int i = 0; i < 600; i++) begin
      fifowr  = ($urandom_range(0, 2) != 0);
      wdata   = 8'($urandom);
      tx_en   = ($urandom_range(0, 3) != 0);
      ovf_clr = ($urandom_range(0, 15) == 0);
      tick();
    end
    fifowr = 1'b0; ovf_clr = 1'b0; tx_en = 1'b1;
    wait_drain(3000);
    check("final_sb_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
